// File: rtl/sha1_pkg.sv
// Shared constants and round helpers for the SHA-1 round engine.
// Controller state encoding, round constants, IV words and f-function selection.
package sha1_pkg;

    localparam logic [1:0] ST_RESET   = 2'b00;
    localparam logic [1:0] ST_INIT    = 2'b01;
    localparam logic [1:0] ST_COMPUTE = 2'b10;
    localparam logic [1:0] ST_FINISH  = 2'b11;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    localparam logic [31:0] IV0 = 32'h67452301;
    localparam logic [31:0] IV1 = 32'hEFCDAB89;
    localparam logic [31:0] IV2 = 32'h98BADCFE;
    localparam logic [31:0] IV3 = 32'h10325476;
    localparam logic [31:0] IV4 = 32'hC3D2E1F0;

    localparam logic [6:0] ROUNDS = 7'd80;
    localparam logic [6:0] T_IDLE = 7'd81;

    function automatic logic [31:0] rol1(input logic [31:0] x);
        return {x[30:0], x[31]};
    endfunction

    function automatic logic [31:0] rol5(input logic [31:0] x);
        return {x[26:0], x[31:27]};
    endfunction

    function automatic logic [31:0] rol30(input logic [31:0] x);
        return {x[1:0], x[31:2]};
    endfunction

    // Ch for rounds 0-19, Maj for 40-59, Parity elsewhere.
    function automatic logic [31:0] f_func(input logic [6:0] t, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] d);
        if (t < 7'd20)      return (b & c) | (~b & d);
        else if (t < 7'd40) return b ^ c ^ d;
        else if (t < 7'd60) return (b & c) | (b & d) | (c & d);
        else                return b ^ c ^ d;
    endfunction

    function automatic logic [31:0] k_of(input logic [6:0] t);
        if (t < 7'd20)      return K0;
        else if (t < 7'd40) return K1;
        else if (t < 7'd60) return K2;
        else                return K3;
    endfunction

endpackage

// File: rtl/sha1_msg_schedule.sv
// SHA-1 message schedule: a 16-word shift buffer that always holds W_t..W_t+15,
// so W_t is simply the head word and each advance appends W_t+16.
module sha1_msg_schedule
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [511:0] block_in,
    input  logic         advance,
    output logic [31:0]  w_t
);

    logic [31:0] w_buf [16];
    logic [31:0] w_new;

    // Relative to the head word t: t+13, t+8, t+2, t give W_t+16.
    assign w_new = rol1(w_buf[13] ^ w_buf[8] ^ w_buf[2] ^ w_buf[0]);
    assign w_t   = w_buf[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) w_buf[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) w_buf[i] <= block_in[511 - 32*i -: 32];
        end else if (advance) begin
            for (int i = 0; i < 15; i++) w_buf[i] <= w_buf[i+1];
            w_buf[15] <= w_new;
        end
    end

endmodule

// File: rtl/sha1_round_engine.sv
// SHA-1 compression datapath driven by the controller state; one round per clock.
// Optional SHA1_CHAIN_EN adds the chain input for multi-block messages.
module sha1_round_engine
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic [1:0]   state,
    input  logic [511:0] block_in,
`ifdef SHA1_CHAIN_EN
    input  logic         chain,
`endif
    output logic [159:0] digest_out,
    output logic         done,
    output logic [6:0]   round_idx
);

    logic [31:0] a, b, c, d, e;
    logic [31:0] h0, h1, h2, h3, h4;
    logic [6:0]  t_q;
    logic        done_q;
    logic [31:0] w_t;
    logic [31:0] temp;
    logic        use_chain;
    logic        sched_load;
    logic        sched_advance;

`ifdef SHA1_CHAIN_EN
    assign use_chain = chain;
`else
    assign use_chain = 1'b0;
`endif

    assign sched_load    = (state == ST_INIT);
    assign sched_advance = (state == ST_COMPUTE) && (t_q < ROUNDS);

    sha1_msg_schedule u_sched (
        .clk      (clk),
        .reset    (reset),
        .load     (sched_load),
        .block_in (block_in),
        .advance  (sched_advance),
        .w_t      (w_t)
    );

    always_comb begin
        temp = rol5(a) + f_func(t_q, b, c, d) + e + k_of(t_q) + w_t;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {a, b, c, d, e}      <= '0;
            {h0, h1, h2, h3, h4} <= '0;
            t_q    <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    t_q    <= '0;
                    done_q <= 1'b0;
                end
                ST_INIT: begin
                    t_q    <= '0;
                    done_q <= 1'b0;
                    if (use_chain) begin
                        // Continue from the previous block's digest.
                        {a, b, c, d, e} <= {h0, h1, h2, h3, h4};
                    end else begin
                        {h0, h1, h2, h3, h4} <= {IV0, IV1, IV2, IV3, IV4};
                        {a, b, c, d, e}      <= {IV0, IV1, IV2, IV3, IV4};
                    end
                end
                ST_COMPUTE: begin
                    if (t_q < ROUNDS) begin
                        e   <= d;
                        d   <= c;
                        c   <= rol30(b);
                        b   <= a;
                        a   <= temp;
                        t_q <= t_q + 7'd1;
                    end else if (t_q == ROUNDS) begin
                        h0     <= h0 + a;
                        h1     <= h1 + b;
                        h2     <= h2 + c;
                        h3     <= h3 + d;
                        h4     <= h4 + e;
                        done_q <= 1'b1;
                        t_q    <= T_IDLE;
                    end
                end
                default: ; // FINISH: everything holds
            endcase
        end
    end

    assign digest_out = {h0, h1, h2, h3, h4};
    assign done       = done_q;
    assign round_idx  = t_q;

endmodule

// File: tb/tb_sha1_round_engine.sv
// Directed bench for sha1_round_engine: table of padded blocks with known digests,
// plus sequences for async reset, INIT abort, COMPUTE->FINISH freeze and idle hold.
module tb_sha1_round_engine;
    import sha1_pkg::*;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   state;
    logic [511:0] block_in;
`ifdef SHA1_CHAIN_EN
    logic         chain;
`endif
    logic [159:0] digest_out;
    logic         done;
    logic [6:0]   round_idx;

    int n_total = 0;
    int n_pass  = 0;

    typedef struct {
        string        name;
        logic [511:0] blk;
        logic [159:0] exp;
    } vec_t;

    vec_t vecs [2];

    localparam logic [511:0] ABC_BLK   = {32'h61626380, {14{32'h0}}, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, {15{32'h0}}};
    localparam logic [159:0] ABC_DIG   = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
    localparam logic [159:0] EMPTY_DIG = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;

    always #5 clk = ~clk;

    sha1_round_engine dut (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .block_in   (block_in),
`ifdef SHA1_CHAIN_EN
        .chain      (chain),
`endif
        .digest_out (digest_out),
        .done       (done),
        .round_idx  (round_idx)
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive a state for one rising edge, then return 1 time unit after it.
    task automatic step(input logic [1:0] st);
        state = st;
        @(posedge clk);
        #1;
    endtask

    task automatic compute(input int n);
        for (int i = 0; i < n; i++) step(ST_COMPUTE);
    endtask

    task automatic do_init(input logic [511:0] blk);
        block_in = blk;
        step(ST_INIT);
        block_in = {16{32'hdeadbeef}};
    endtask

    initial begin
        vecs[0] = '{name: "abc",   blk: ABC_BLK,   exp: ABC_DIG};
        vecs[1] = '{name: "empty", blk: EMPTY_BLK, exp: EMPTY_DIG};

        reset    = 1'b1;
        state    = ST_RESET;
        block_in = '0;
`ifdef SHA1_CHAIN_EN
        chain    = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("rst_digest", digest_out, '0);
        check("rst_done", {159'b0, done}, 160'd0);
        check("rst_round", {153'b0, round_idx}, 160'd0);
        reset = 1'b0;
        step(ST_RESET);

        for (int v = 0; v < 2; v++) begin
            do_init(vecs[v].blk);
            compute(80);
            check($sformatf("%s_done_e80", vecs[v].name), {159'b0, done}, 160'd0);
            compute(1);
            check($sformatf("%s_done_e81", vecs[v].name), {159'b0, done}, 160'd1);
            check($sformatf("%s_digest", vecs[v].name), digest_out, vecs[v].exp);
            check($sformatf("%s_round", vecs[v].name), {153'b0, round_idx}, 160'd81);
            step(ST_FINISH);
            check($sformatf("%s_fin_done", vecs[v].name), {159'b0, done}, 160'd1);
            check($sformatf("%s_fin_digest", vecs[v].name), digest_out, vecs[v].exp);
            step(ST_RESET);
            check($sformatf("%s_rst_done", vecs[v].name), {159'b0, done}, 160'd0);
            check($sformatf("%s_rst_hold", vecs[v].name), digest_out, vecs[v].exp);
        end

        // Async reset in the middle of a computation.
        do_init(ABC_BLK);
        compute(40);
        #2 reset = 1'b1;
        #1;
        check("async_done", {159'b0, done}, 160'd0);
        check("async_digest", digest_out, '0);
        #1 reset = 1'b0;
        step(ST_RESET);
        do_init(ABC_BLK);
        compute(81);
        check("post_async_done", {159'b0, done}, 160'd1);
        check("post_async_digest", digest_out, ABC_DIG);

        // Re-INIT mid-computation aborts and restarts with a new block.
        do_init(ABC_BLK);
        compute(50);
        do_init(EMPTY_BLK);
        check("abort_done", {159'b0, done}, 160'd0);
        check("abort_round", {153'b0, round_idx}, 160'd0);
        compute(80);
        check("abort_done_e80", {159'b0, done}, 160'd0);
        compute(1);
        check("abort_digest", digest_out, EMPTY_DIG);

        // COMPUTE idles in place after done.
        compute(200);
        check("idle_done", {159'b0, done}, 160'd1);
        check("idle_digest", digest_out, EMPTY_DIG);
        check("idle_round", {153'b0, round_idx}, 160'd81);

        // FINISH before done freezes the rounds; resuming completes correctly.
        do_init(ABC_BLK);
        compute(30);
        for (int i = 0; i < 5; i++) step(ST_FINISH);
        check("freeze_round", {153'b0, round_idx}, 160'd30);
        check("freeze_done", {159'b0, done}, 160'd0);
        compute(50);
        check("freeze_done_e80", {159'b0, done}, 160'd0);
        compute(1);
        check("freeze_digest", digest_out, ABC_DIG);

`ifdef SHA1_CHAIN_EN
        chain = 1'b0;
        do_init({32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000});
        compute(81);
        step(ST_FINISH);
        chain = 1'b1;
        do_init({{15{32'h0}}, 32'h000001c0});
        chain = 1'b0;
        compute(81);
        check("chain_done", {159'b0, done}, 160'd1);
        check("chain_digest", digest_out, 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sha1_round_engine.md
# sha1_round_engine

Datapath stage directly downstream of the SHA-1 state controller: consumes its 2-bit `state` and produces the `done` flag the controller waits on. On INIT it latches one padded 512-bit message block and the chaining value. During COMPUTE it runs the 80 SHA-1 rounds at one round per clock, then adds the working variables into the digest. It holds the 160-bit digest for readout in FINISH.

## Interface
- No parameters; all constants live in `sha1_pkg`.
- `clk` input 1 — single clock; all state updates on its rising edge.
- `reset` input 1 — asynchronous, active-high; clears all registers.
- `state` input 2 — controller state: 00 RESET, 01 INIT, 10 COMPUTE, 11 FINISH.
- `block_in` input 512 — padded message block; word 0 is `block_in[511:480]`; sampled only in INIT.
- `chain` input 1 — present only with `SHA1_CHAIN_EN`; sampled in INIT.
- `digest_out` output 160 — H0..H4, with H0 in `[159:128]`.
- `done` output 1 — registered; high once the digest for the current block is valid.

## Operation
- Async `reset`:
  - `digest_out`, A..E, schedule buffer and round counter go to 0.
  - `done` goes to 0.
- RESET state (00), synchronous:
  - `done` goes to 0 and the counter `t` goes to 0.
  - Digest, working registers and buffer hold.
- INIT state (01), every cycle it is present:
  - Load the 16-word buffer from `block_in`.
  - Load H0..H4 with the IV: 67452301, EFCDAB89, 98BADCFE, 10325476, C3D2E1F0.
  - Load A..E with the same values; `t` goes to 0 and `done` goes to 0.
  - Re-entering INIT mid-computation aborts the current block and restarts cleanly.
- COMPUTE state (10):
  - While `t` < 80, each edge executes round `t`:
    - TEMP = rol5(A) + f_t(B,C,D) + E + K_t + W_t
    - E=D, D=C, C=rol30(B), B=A, A=TEMP
    - `t` increments.
  - When `t` = 80, the next edge adds A..E into H0..H4, sets `done` to 1 and sets `t` to 81.
  - When `t` = 81, `t` saturates and nothing changes (idle).
- f and K by round range (all arithmetic is mod 2^32, carries dropped):
  - t 0–19: f = Ch, K = 5A827999.
  - t 20–39: f = Parity, K = 6ED9EBA1.
  - t 40–59: f = Maj, K = 8F1BBCDC.
  - t 60–79: f = Parity, K = CA62C1D6.
- Schedule:
  - For t < 16, W_t is buffer word t.
  - For t ≥ 16, W_t = rol1(W[t-3] ^ W[t-8] ^ W[t-14] ^ W[t-16]).
  - The buffer is a 16-entry shift register: it shifts one word per round and appends the newly computed word.
- FINISH state (11): everything holds; `done` stays 1 and `digest_out` stays stable.
- COMPUTE → FINISH before `done`: registers freeze (the controller does not generate this, but it is legal).

## Timing
- Latency: `done` rises on the 81st rising edge spent in COMPUTE after INIT.
- `digest_out` is valid on the same edge that `done` rises.
- `done` is a registered output.
- `done` falls on the first edge in INIT or RESET, or immediately on async `reset`.
- `block_in` needs to be stable only during INIT cycles.
- Counter: 7 bits, saturating at 81.

## Configuration
- `SHA1_CHAIN_EN` defined:
  - Adds the `chain` input.
  - INIT with `chain` = 1 keeps H0..H4 and loads A..E from the current H, so multi-block messages are hashed.
  - INIT with `chain` = 0 loads the IV.
- `SHA1_CHAIN_EN` undefined:
  - No `chain` port.
  - INIT always loads the IV; single-block hashing only.

## Structure
- `sha1_pkg` holds:
  - State encoding constants ST_RESET, ST_INIT, ST_COMPUTE, ST_FINISH.
  - The four K constants and the five IV words.
  - f-function selection helpers.
- Sub-module `sha1_msg_schedule`:
  - The 16-word shift buffer and the W_t generator.
  - Ports: `clk`, `reset`, `load`, `block_in`, `advance`, `w_t`.

## Test plan
- Reset, INIT with padded "abc", then COMPUTE → `done` on edge 81; `digest_out` = a9993e36 4706816a ba3e2571 7850c26c 9cd0d89d.
- Empty-message padded block → `digest_out` = da39a3ee 5e6b4b0d 3255bfef 95601890 afd80709.
- Assert async `reset` at COMPUTE edge 40 → `done` = 0 and `digest_out` = 0 immediately; then a fresh "abc" run gives the correct digest.
- Return to INIT at COMPUTE edge 50 with the empty block → `done` = 0; the subsequent run yields the empty-message digest at edge 81.
- Hold COMPUTE for 200 edges after `done` → `digest_out` unchanged, `done` stays 1, `t` stays 81.
- With `SHA1_CHAIN_EN`, two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (second INIT with `chain` = 1) → 84983e44 1c3bd26e baae4aa1 f95129e5 e54670f1.
